// File: rtl/genius_pkg.sv
// Shared constants and types for the Genius game datapath.
// Holds tick rate, level width, counter width, colour codes and timer states.
package genius_pkg;

    localparam int TICK_DIV_DEF = 50000;
    localparam int LEVEL_W      = 4;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        C_GREEN  = 2'd0,
        C_RED    = 2'd1,
        C_BLUE   = 2'd2,
        C_YELLOW = 2'd3
    } colour_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/genius_oneshot.sv
// One-shot ms timer: load_i ms at start, counts TICK_DIV clocks per ms.
// Ports: CLK, RESET (sync, high), start_i, load_i -> end_o, busy_o, remain_o.
module genius_oneshot
    import genius_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             end_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] remain_o
);

    localparam int SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(TICK_DIV - 1);

    tmr_state_t       state_q, state_d;
    logic [SW-1:0]    sub_q, sub_d;
    logic [CNT_W-1:0] ms_q, ms_d;
    logic             end_q, end_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= T_IDLE;
            sub_q   <= '0;
            ms_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            ms_q    <= ms_d;
            end_q   <= end_d;
        end
    end

    // Start always wins, so a start on the expiry edge
    // restarts the run and suppresses that END pulse.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        ms_d    = ms_q;
        end_d   = 1'b0;
        if (start_i) begin
            state_d = T_RUN;
            sub_d   = '0;
            ms_d    = load_i;
        end else begin
            unique case (state_q)
                T_IDLE: begin
                    sub_d = '0;
                    ms_d  = '0;
                end
                T_RUN: begin
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (ms_q <= CNT_W'(1)) begin
                            state_d = T_IDLE;
                            ms_d    = '0;
                            end_d   = 1'b1;
                        end else begin
                            ms_d = ms_q - CNT_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
                default: state_d = T_IDLE;
            endcase
        end
    end

    // ms_q is forced to zero whenever idle, so it doubles as REMAIN.
    assign end_o    = end_q;
    assign busy_o   = (state_q == T_RUN);
    assign remain_o = ms_q;

endmodule

// File: rtl/genius_timer_ctrl.sv
// Game timers: timer 1 (display time, shrinks with LEVEL), timer 2 (input timeout).
// Ports: CLK, RESET, START_1/2, LEVEL -> END_1/2, BUSY_1/2, REMAIN_2.
module genius_timer_ctrl
    import genius_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int T1_BASE_MS = 800,
    parameter int T1_STEP_MS = 40,
    parameter int T1_MIN_MS  = 200,
    parameter int T2_MS      = 3000,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START_1,
    input  logic               START_2,
    input  logic [LEVEL_W-1:0] LEVEL,
    output logic               END_1,
    output logic               END_2,
    output logic               BUSY_1,
    output logic               BUSY_2,
    output logic [CNT_W-1:0]   REMAIN_2
);

    localparam int XW    = CNT_W + 4;
    localparam int MIN_E = (T1_MIN_MS < 1) ? 1 : T1_MIN_MS;

    localparam logic signed [XW-1:0] BASE_X = XW'(T1_BASE_MS);
    localparam logic signed [XW-1:0] STEP_X = XW'(T1_STEP_MS);
    localparam logic signed [XW-1:0] MIN_X  = XW'(MIN_E);

    logic signed [XW-1:0] lvl_x;
    logic signed [XW-1:0] diff_x;
    logic signed [XW-1:0] n1_x;
    logic [CNT_W-1:0]     n1;
    logic [CNT_W-1:0]     rem1_unused;

    // Signed, widened subtraction so deep levels clamp to the floor.
    always_comb begin
        lvl_x  = XW'(LEVEL);
        diff_x = BASE_X - lvl_x * STEP_X;
        n1_x   = (diff_x < MIN_X) ? MIN_X : diff_x;
        n1     = CNT_W'(n1_x);
    end

    genius_oneshot #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_t1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .start_i  (START_1),
        .load_i   (n1),
        .end_o    (END_1),
        .busy_o   (BUSY_1),
        .remain_o (rem1_unused)
    );

    genius_oneshot #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_t2 (
        .CLK      (CLK),
        .RESET    (RESET),
        .start_i  (START_2),
        .load_i   (CNT_W'(T2_MS)),
        .end_o    (END_2),
        .busy_o   (BUSY_2),
        .remain_o (REMAIN_2)
    );

endmodule

// File: tb/tb_genius_timer_ctrl.sv
// Bench for genius_timer_ctrl: END pulses scoreboarded by edge number,
// BUSY/REMAIN checked directly at hand-computed edges.
module tb_genius_timer_ctrl;

    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START_1 = 1'b0;
    logic          START_2 = 1'b0;
    logic [3:0]    LEVEL = 4'd0;
    logic          END_1, END_2, BUSY_1, BUSY_2;
    logic [CW-1:0] REMAIN_2;

    genius_timer_ctrl #(
        .TICK_DIV   (4),
        .T1_BASE_MS (10),
        .T1_STEP_MS (2),
        .T1_MIN_MS  (3),
        .T2_MS      (20),
        .CNT_W      (CW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START_1  (START_1),
        .START_2  (START_2),
        .LEVEL    (LEVEL),
        .END_1    (END_1),
        .END_2    (END_2),
        .BUSY_1   (BUSY_1),
        .BUSY_2   (BUSY_2),
        .REMAIN_2 (REMAIN_2)
    );

    always #5 CLK = ~CLK;

    int edge_n = 0;
    always @(posedge CLK) edge_n <= edge_n + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int q1[$];
    int q2[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d want %0d", nm, edge_n, act, exp);
        end
    endtask

    // Monitor: every END pulse must match the head of its queue.
    always @(negedge CLK) begin
        if (END_1) begin
            if (q1.size() == 0) chk("end1_unexpected", edge_n, -1);
            else chk("end1_edge", edge_n, q1.pop_front());
        end
        if (END_2) begin
            if (q2.size() == 0) chk("end2_unexpected", edge_n, -1);
            else chk("end2_edge", edge_n, q2.pop_front());
        end
    end

    // Return at the negedge just before edge t is sampled.
    task automatic goto(input int t);
        int b = 0;
        while (edge_n < t - 1 && b < 2000) begin
            @(negedge CLK);
            b++;
        end
    endtask

    task automatic at(input int t);
        goto(t + 1);
    endtask

    task automatic drain();
        int b = 0;
        while ((q1.size() != 0 || q2.size() != 0) && b < 400) begin
            @(negedge CLK);
            b++;
        end
        chk("drain_timeout", b < 400 ? 1 : 0, 1);
        repeat (4) @(negedge CLK);
    endtask

    task automatic pulse1(input logic [3:0] lv);
        LEVEL = lv;
        START_1 = 1'b1;
        @(negedge CLK);
        START_1 = 1'b0;
    endtask

    int e0, r;

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_end1", END_1, 0);
        chk("rst_end2", END_2, 0);
        chk("rst_busy1", BUSY_1, 0);
        chk("rst_busy2", BUSY_2, 0);
        chk("rst_remain", REMAIN_2, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // 1: durations per level
        e0 = edge_n + 1;
        q1.push_back(e0 + 40);
        pulse1(4'd0);
        chk("t1_busy_e0", BUSY_1, 1);
        at(e0 + 39);
        chk("t1_busy_39", BUSY_1, 1);
        at(e0 + 40);
        chk("t1_busy_40", BUSY_1, 0);
        drain();
        e0 = edge_n + 1;
        q1.push_back(e0 + 24);
        pulse1(4'd2);
        drain();
        e0 = edge_n + 1;
        q1.push_back(e0 + 12);
        pulse1(4'd5);
        drain();
        e0 = edge_n + 1;
        q1.push_back(e0 + 12);
        pulse1(4'd15);
        at(e0 + 11);
        chk("t1_l15_busy11", BUSY_1, 1);
        drain();

        // 2: retrigger, and start on the expiry edge
        e0 = edge_n + 1;
        q1.push_back(e0 + 60);
        pulse1(4'd0);
        goto(e0 + 20);
        pulse1(4'd0);
        drain();
        e0 = edge_n + 1;
        q1.push_back(e0 + 80);
        pulse1(4'd0);
        goto(e0 + 40);
        pulse1(4'd0);
        chk("t1_restart_busy", BUSY_1, 1);
        drain();

        // 3: REMAIN_2 countdown
        e0 = edge_n + 1;
        q2.push_back(e0 + 80);
        START_2 = 1'b1;
        @(negedge CLK);
        START_2 = 1'b0;
        chk("rem_e0", REMAIN_2, 20);
        chk("t2_busy_e0", BUSY_2, 1);
        at(e0 + 3);
        chk("rem_3", REMAIN_2, 20);
        at(e0 + 4);
        chk("rem_4", REMAIN_2, 19);
        at(e0 + 8);
        chk("rem_8", REMAIN_2, 18);
        at(e0 + 79);
        chk("rem_79", REMAIN_2, 1);
        at(e0 + 80);
        chk("rem_80", REMAIN_2, 0);
        chk("t2_busy_80", BUSY_2, 0);
        drain();

        // 4: concurrent and simultaneous expiry
        e0 = edge_n + 1;
        q1.push_back(e0 + 40);
        q2.push_back(e0 + 80);
        START_2 = 1'b1;
        pulse1(4'd0);
        START_2 = 1'b0;
        drain();
        e0 = edge_n + 1;
        q2.push_back(e0 + 80);
        q1.push_back(e0 + 80);
        START_2 = 1'b1;
        @(negedge CLK);
        START_2 = 1'b0;
        goto(e0 + 40);
        pulse1(4'd0);
        drain();

        // 5: reset mid-run, START held through reset
        e0 = edge_n + 1;
        START_2 = 1'b1;
        pulse1(4'd0);
        START_2 = 1'b0;
        goto(e0 + 10);
        RESET = 1'b1;
        START_1 = 1'b1;
        @(negedge CLK);
        chk("rst_mid_busy1", BUSY_1, 0);
        chk("rst_mid_busy2", BUSY_2, 0);
        chk("rst_mid_rem", REMAIN_2, 0);
        repeat (3) @(negedge CLK);
        chk("rst_hold_busy1", BUSY_1, 0);
        r = edge_n + 1;
        q1.push_back(r + 40);
        RESET = 1'b0;
        @(negedge CLK);
        START_1 = 1'b0;
        chk("post_rst_busy1", BUSY_1, 1);
        drain();

        // 6: LEVEL change mid-run
        e0 = edge_n + 1;
        q1.push_back(e0 + 40);
        pulse1(4'd0);
        goto(e0 + 5);
        LEVEL = 4'd7;
        drain();
        e0 = edge_n + 1;
        q1.push_back(e0 + 12);
        pulse1(4'd7);
        drain();

        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
